// File: rtl/alu_seq_ctrl.sv
// Multi-cycle sequencer that runs a NIB*4-bit operation through an external 4-bit ALU,
// one nibble per cycle, least-significant first, with carry chained between arithmetic passes.
module alu_seq_ctrl #(
    parameter  int NIB = 2,
    localparam int W   = 4 * NIB
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [2:0]   req_op,
    input  logic [W-1:0] req_a,
    input  logic [W-1:0] req_b,
    input  logic         req_cin,
    output logic         resp_valid,
    input  logic         resp_ready,
    output logic [W-1:0] resp_r,
    output logic         resp_zero,
    output logic         resp_carry,
    output logic         resp_sign,
    output logic [3:0]   alu_a,
    output logic [3:0]   alu_b,
    output logic         alu_c_in,
    output logic [1:0]   alu_op,
    output logic         alu_l,
    input  logic [3:0]   alu_r,
    input  logic         alu_zero,
    input  logic         alu_c_out,
    input  logic         alu_sign
);

    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_result;
    logic             r_zero_acc;
    logic             r_carry;
    logic             r_sign;

    logic [2:0]       r_op;
    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic             r_cin;

    logic             w_arith;
    logic             w_accept;
    logic [3:0]       w_alu_a;
    logic [3:0]       w_alu_b;
    logic             w_alu_c_in;
    logic [1:0]       w_alu_op;
    logic             w_alu_l;

    assign w_arith  = ~r_op[2];
    assign w_accept = (r_state == S_IDLE) && req_valid;

    // Operand latch carries no reset: it is only observed while in RUN.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_op  <= req_op;
            r_a   <= req_a;
            r_b   <= req_b;
            r_cin <= req_cin;
        end
    end

    // ALU drive is quiet (all zero) outside RUN.
    always_comb begin
        w_alu_a    = 4'h0;
        w_alu_b    = 4'h0;
        w_alu_c_in = 1'b0;
        w_alu_op   = 2'b00;
        w_alu_l    = 1'b0;
        if (r_state == S_RUN) begin
            w_alu_a = r_a[4*r_idx +: 4];
            w_alu_b = r_b[4*r_idx +: 4];
            w_alu_l = r_op[2];
            if (!w_arith) begin
                w_alu_op = r_op[1:0];
            end else begin
                w_alu_op = r_op[1] ? 2'b00 : 2'b10;
                if (r_idx != '0) begin
                    w_alu_c_in = r_carry;
                end else begin
                    case (r_op[1:0])
                        2'b01:   w_alu_c_in = r_cin;
                        2'b10:   w_alu_c_in = 1'b1;
                        default: w_alu_c_in = 1'b0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_result   <= '0;
            r_zero_acc <= 1'b0;
            r_carry    <= 1'b0;
            r_sign     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_state    <= S_RUN;
                        r_idx      <= '0;
                        r_result   <= '0;
                        r_zero_acc <= 1'b1;
                    end
                end
                S_RUN: begin
                    r_result[4*r_idx +: 4] <= alu_r;
                    r_zero_acc             <= r_zero_acc & alu_zero;
                    // Logic ops never produce a carry, so masking here keeps resp_carry at 0 for them.
                    r_carry                <= alu_c_out & w_arith;
                    r_sign                 <= alu_sign;
                    if (r_idx == LAST_IDX) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    if (resp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign resp_r     = r_result;
    assign resp_zero  = r_zero_acc;
    assign resp_carry = r_carry;
    assign resp_sign  = r_sign;

    assign alu_a    = w_alu_a;
    assign alu_b    = w_alu_b;
    assign alu_c_in = w_alu_c_in;
    assign alu_op   = w_alu_op;
    assign alu_l    = w_alu_l;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl (NIB=2) driving a behavioural 4-bit ALU model.
module tb_alu_seq_ctrl;

    localparam int NIB = 2;
    localparam int W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_r;
    logic         resp_zero;
    logic         resp_carry;
    logic         resp_sign;
    logic [3:0]   alu_a;
    logic [3:0]   alu_b;
    logic         alu_c_in;
    logic [1:0]   alu_op;
    logic         alu_l;
    logic [3:0]   alu_r;
    logic         alu_zero;
    logic         alu_c_out;
    logic         alu_sign;

    int checks = 0;
    int errors = 0;

    alu_seq_ctrl #(.NIB(NIB)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_r     (resp_r),
        .resp_zero  (resp_zero),
        .resp_carry (resp_carry),
        .resp_sign  (resp_sign),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_c_in   (alu_c_in),
        .alu_op     (alu_op),
        .alu_l      (alu_l),
        .alu_r      (alu_r),
        .alu_zero   (alu_zero),
        .alu_c_out  (alu_c_out),
        .alu_sign   (alu_sign)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: l=0 arithmetic (10: A+B+cin, 00: A+cin), l=1 logic (AND/OR/XOR/NOR).
    logic [4:0] m_sum;
    always_comb begin
        m_sum = 5'd0;
        if (!alu_l) begin
            case (alu_op)
                2'b10:   m_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_c_in};
                2'b01:   m_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'd0, alu_c_in};
                default: m_sum = {1'b0, alu_a} + {4'd0, alu_c_in};
            endcase
        end else begin
            case (alu_op)
                2'b00:   m_sum = {1'b0, alu_a & alu_b};
                2'b01:   m_sum = {1'b0, alu_a | alu_b};
                2'b10:   m_sum = {1'b0, alu_a ^ alu_b};
                default: m_sum = {1'b0, ~(alu_a | alu_b)};
            endcase
        end
    end
    assign alu_r     = m_sum[3:0];
    assign alu_c_out = m_sum[4];
    assign alu_zero  = (m_sum[3:0] == 4'h0);
    assign alu_sign  = m_sum[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_alu_quiet(input string tag);
        check({tag, " alu_a"}, 32'(alu_a), 32'h0);
        check({tag, " alu_b"}, 32'(alu_b), 32'h0);
        check({tag, " alu_c_in"}, 32'(alu_c_in), 32'h0);
        check({tag, " alu_op"}, 32'(alu_op), 32'h0);
        check({tag, " alu_l"}, 32'(alu_l), 32'h0);
    endtask

    // Issues one request and walks the passes; leaves the block in DONE.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input logic [1:0] eop,
                          input logic [1:0] ecin, input logic [7:0] er, input logic ec,
                          input logic ez, input logic es);
        @(negedge clk);
        check({tag, " req_ready"}, 32'(req_ready), 32'h1);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_cin   = cin;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        req_cin   = 1'b0;
        for (int p = 0; p < NIB; p++) begin
            check($sformatf("%s p%0d alu_a", tag, p), 32'(alu_a), 32'(a[4*p +: 4]));
            check($sformatf("%s p%0d alu_b", tag, p), 32'(alu_b), 32'(b[4*p +: 4]));
            check($sformatf("%s p%0d alu_l", tag, p), 32'(alu_l), 32'(op[2]));
            check($sformatf("%s p%0d alu_op", tag, p), 32'(alu_op), 32'(eop));
            check($sformatf("%s p%0d alu_c_in", tag, p), 32'(alu_c_in), 32'(ecin[p]));
            check($sformatf("%s p%0d resp_valid", tag, p), 32'(resp_valid), 32'h0);
            @(posedge clk);
            #1;
        end
        check({tag, " resp_valid"}, 32'(resp_valid), 32'h1);
        check({tag, " req_ready busy"}, 32'(req_ready), 32'h0);
        check({tag, " resp_r"}, 32'(resp_r), 32'(er));
        check({tag, " resp_carry"}, 32'(resp_carry), 32'(ec));
        check({tag, " resp_zero"}, 32'(resp_zero), 32'(ez));
        check({tag, " resp_sign"}, 32'(resp_sign), 32'(es));
        check_alu_quiet({tag, " done"});
    endtask

    task automatic release_resp(input string tag);
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({tag, " release resp_valid"}, 32'(resp_valid), 32'h0);
        check({tag, " release req_ready"}, 32'(req_ready), 32'h1);
    endtask

    initial begin
        reset      = 1'b0;
        req_valid  = 1'b0;
        req_op     = '0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = 1'b0;
        resp_ready = 1'b0;

        #12;
        check("reset req_ready", 32'(req_ready), 32'h1);
        check("reset resp_valid", 32'(resp_valid), 32'h0);
        check("reset resp_r", 32'(resp_r), 32'h0);
        check("reset resp_zero", 32'(resp_zero), 32'h0);
        check("reset resp_carry", 32'(resp_carry), 32'h0);
        check("reset resp_sign", 32'(resp_sign), 32'h0);
        check_alu_quiet("reset");
        @(negedge clk);
        reset = 1'b1;

        run_op("ADD7F", 3'b000, 8'h7F, 8'h01, 1'b0, 2'b10, 2'b10, 8'h80, 1'b0, 1'b0, 1'b1);
        release_resp("ADD7F");
        run_op("ADDFF", 3'b000, 8'hFF, 8'h01, 1'b0, 2'b10, 2'b10, 8'h00, 1'b1, 1'b1, 1'b0);
        release_resp("ADDFF");
        run_op("INCFF", 3'b010, 8'hFF, 8'h00, 1'b0, 2'b00, 2'b11, 8'h00, 1'b1, 1'b1, 1'b0);
        release_resp("INCFF");
        run_op("ADC0F", 3'b001, 8'h0F, 8'h00, 1'b1, 2'b10, 2'b11, 8'h10, 1'b0, 1'b0, 1'b0);
        release_resp("ADC0F");
        run_op("PASSA5", 3'b011, 8'hA5, 8'h3C, 1'b1, 2'b00, 2'b00, 8'hA5, 1'b0, 1'b0, 1'b1);
        release_resp("PASSA5");
        run_op("AND", 3'b100, 8'h3C, 8'h0F, 1'b1, 2'b00, 2'b00, 8'h0C, 1'b0, 1'b0, 1'b0);
        release_resp("AND");
        run_op("OR", 3'b101, 8'h3C, 8'h0F, 1'b0, 2'b01, 2'b00, 8'h3F, 1'b0, 1'b0, 1'b0);
        release_resp("OR");
        run_op("XOR", 3'b110, 8'hFF, 8'hFF, 1'b0, 2'b10, 2'b00, 8'h00, 1'b0, 1'b1, 1'b0);
        release_resp("XOR");

        // Backpressure: hold the response for 5 cycles with a stray request in the middle.
        run_op("BP", 3'b000, 8'h12, 8'h34, 1'b0, 2'b10, 2'b00, 8'h46, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("BP c%0d resp_valid", c), 32'(resp_valid), 32'h1);
            check($sformatf("BP c%0d req_ready", c), 32'(req_ready), 32'h0);
            check($sformatf("BP c%0d resp_r", c), 32'(resp_r), 32'h46);
            check($sformatf("BP c%0d resp_flags", c), {29'd0, resp_carry, resp_zero, resp_sign}, 32'h0);
            req_valid = (c == 2);
            req_op    = 3'b000;
            req_a     = (c == 2) ? 8'h11 : 8'h00;
            req_b     = (c == 2) ? 8'h11 : 8'h00;
        end
        @(negedge clk);
        req_valid = 1'b0;
        req_a     = '0;
        req_b     = '0;
        check("BP still held", 32'(resp_r), 32'h46);
        release_resp("BP");
        @(negedge clk);
        check("BP no stray accept", 32'(req_ready), 32'h1);

        // Asynchronous reset in the middle of RUN, on the second pass.
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 3'b000;
        req_a     = 8'h5A;
        req_b     = 8'h33;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("RST mid alu_a", 32'(alu_a), 32'h5);
        check("RST mid alu_b", 32'(alu_b), 32'h3);
        reset = 1'b0;
        #1;
        check("RST req_ready", 32'(req_ready), 32'h1);
        check("RST resp_valid", 32'(resp_valid), 32'h0);
        check("RST resp_r", 32'(resp_r), 32'h0);
        check_alu_quiet("RST");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("RST no partial resp", 32'(resp_valid), 32'h0);

        run_op("ADD99", 3'b000, 8'h99, 8'h99, 1'b0, 2'b10, 2'b10, 8'h32, 1'b1, 1'b0, 1'b0);
        release_resp("ADD99");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
